toeplitz_deserializer: RTL

TOEPLITZ_DESERIALIZER -- requirements
Module: toeplitz_deserializer

---
 rtl/toeplitz_deserializer.sv | 68 ++++++
 1 files changed

// File: rtl/toeplitz_deserializer.sv
// toeplitz_deserializer: packs qbiten-gated serial bits MSB-first into W-bit words,
// tags the final word of each L-bit frame and buffers words in a DEPTH-entry FIFO.
module toeplitz_deserializer #(
  parameter int L = 128,
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         qbit,
  input  logic         qbiten,
  input  logic         sync,
  output logic [W-1:0] dout,
  output logic         dlast,
  output logic         dvalid,
  input  logic         dready,
  output logic         ovf,
  output logic [15:0]  frames
);
  localparam int NW = L / W;
  localparam int BW = $clog2(W);
  localparam int CW = NW > 1 ? $clog2(NW) : 1;
  localparam int AW = $clog2(DEPTH);
  logic [BW-1:0] bcnt;
  logic [CW-1:0] wcnt;
  logic [W-1:0]  sr, word;
  logic [AW:0]   wptr, rptr;
  logic [W:0]    mem [DEPTH];
  logic          full, pop, done, push, last;
  always_comb begin
    word = {sr[W-2:0], qbit};
    done = qbiten && !sync && bcnt == BW'(W-1);
    last = wcnt == CW'(NW-1);
    full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    dvalid = wptr != rptr;
    pop = dvalid && dready;
    push = done && (!full || pop);
    dout = dvalid ? mem[rptr[AW-1:0]][W-1:0] : '0;
    dlast = dvalid && mem[rptr[AW-1:0]][W];
  end
  // A word completing into a full FIFO is dropped but still advances the counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bcnt <= '0;
      wcnt <= '0;
      sr <= '0;
      wptr <= '0;
      rptr <= '0;
      ovf <= 1'b0;
      frames <= '0;
    end else begin
      if (qbiten) sr <= word;
      if (sync) begin
        bcnt <= BW'(qbiten);
        wcnt <= '0;
      end else if (qbiten) begin
        bcnt <= done ? '0 : bcnt + BW'(1);
        if (done) wcnt <= last ? '0 : wcnt + CW'(1);
      end
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop) rptr <= rptr + (AW+1)'(1);
      if (done && full && !pop) ovf <= 1'b1;
      if (push && last) frames <= frames + 16'd1;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= {last, word};
endmodule
